// File: rtl/frame_writer_pkg.sv
// frame_writer_pkg: shared pixel, write-request and frame state types.
package frame_writer_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic [7:0] a;
   } pixel_t;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} frame_state_t;

   typedef struct packed {
      logic [31:0] addr;
      pixel_t      data;
   } write_req_t;

   localparam int BYTES_PER_PIXEL = 4;

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_RUN   = RUN;
   localparam logic [1:0] S_DRAIN = DRAIN;
   localparam logic [1:0] S_DONE  = DONE;

endpackage

// File: rtl/frame_writer_fifo.sv
// pixel_fifo: synchronous first-word-fall-through FIFO; dout holds the last popped entry while empty.
module pixel_fifo
   import frame_writer_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter type T = write_req_t
)(
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  logic pop,
   input  T     din,
   output T     dout,
   output logic full,
   output logic empty,
   output logic single
);

   localparam int AW = $clog2(DEPTH);

   T mem [DEPTH];
   T last;
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0] count;
   logic do_push, do_pop;

   assign full = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign single = count == (AW+1)'(1);
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign dout = empty ? last : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
         last <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            last <= mem[rd_ptr];
         end
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/frame_writer.sv
// frame_writer: tags raster pixels with framebuffer byte addresses, buffers them
// and issues valid/ready memory writes, pulsing frame_done once the frame is written.
module frame_writer
   import frame_writer_pkg::*;
#(
   parameter int WIDTH = 640,
   parameter int HEIGHT = 480,
   parameter int ADDR_W = 32,
   parameter int FIFO_DEPTH = 8
)(
   input  logic              pixel_clk,
   input  logic              pixel_rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              pixel_valid,
   input  logic [31:0]       pixel_data,
   output logic              pixel_ready,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              busy,
   output logic              frame_done
);

   localparam int XW = $clog2(WIDTH + 1);
   localparam int YW = $clog2(HEIGHT + 1);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      pixel_t            data;
   } req_t;

   logic [1:0] state;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [ADDR_W-1:0] base, byte_offset;
   logic full, empty, single, accept, pop, x_wrap, last_px;
   req_t din, dout;

   assign pixel_ready = state == S_RUN && !full;
   assign accept = pixel_valid && pixel_ready;
   assign wr_valid = !empty;
   assign pop = wr_valid && wr_ready;
   assign x_wrap = x == XW'(WIDTH - 1);
   assign last_px = x_wrap && y == YW'(HEIGHT - 1);
   assign din = '{addr: base + byte_offset, data: pixel_t'(pixel_data)};
   assign wr_addr = dout.addr;
   assign wr_data = dout.data;
   assign busy = state != S_IDLE;
   assign frame_done = state == S_DONE;

   always_ff @(posedge pixel_clk) begin
      if (!pixel_rst_n) begin
         state <= S_IDLE;
         x <= '0;
         y <= '0;
         base <= '0;
         byte_offset <= '0;
      end else begin
         if (state == S_IDLE && start) begin
            state <= S_RUN;
            base <= base_addr;
            x <= '0;
            y <= '0;
            byte_offset <= '0;
         end
         if (accept) begin
            byte_offset <= byte_offset + ADDR_W'(BYTES_PER_PIXEL);
            x <= x_wrap ? '0 : x + XW'(1);
            y <= x_wrap ? y + YW'(1) : y;
            if (last_px) state <= S_DRAIN;
         end
         // Leave DRAIN on the edge that pops the final entry so DONE follows the last write directly
         if (state == S_DRAIN && (empty || (pop && single))) state <= S_DONE;
         if (state == S_DONE) state <= S_IDLE;
      end
   end

   pixel_fifo #(.DEPTH(FIFO_DEPTH), .T(req_t)) u_fifo (
      .clk(pixel_clk),
      .rst_n(pixel_rst_n),
      .push(accept),
      .pop(pop),
      .din(din),
      .dout(dout),
      .full(full),
      .empty(empty),
      .single(single)
   );

endmodule

// File: tb/tb_frame_writer.sv
// tb_frame_writer: directed frames with a write scoreboard filled on accepts and drained on writes.
module tb_frame_writer;

   logic clk = 0, rst_n = 0, start = 0, pixel_valid = 0, wr_ready = 0;
   logic [15:0] base_addr = 0;
   logic [31:0] pixel_data = 0;
   logic pixel_ready, wr_valid, busy, frame_done;
   logic [15:0] wr_addr;
   logic [31:0] wr_data;
   int checks = 0, failures = 0, cyc = 0, nwr = 0, acc_cnt = 0, done_cnt = 0;
   int last_pop_cyc = 0, exp_idx = 0, a0 = 0, w0 = 0;
   logic [15:0] exp_base = 0, last_addr = 0;
   logic [47:0] sb [$];
   logic [47:0] e;

   frame_writer #(.WIDTH(4), .HEIGHT(2), .ADDR_W(16), .FIFO_DEPTH(4)) dut (
      .pixel_clk(clk),
      .pixel_rst_n(rst_n),
      .start(start),
      .base_addr(base_addr),
      .pixel_valid(pixel_valid),
      .pixel_data(pixel_data),
      .pixel_ready(pixel_ready),
      .wr_valid(wr_valid),
      .wr_ready(wr_ready),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .busy(busy),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Handshakes seen at the falling edge complete on the following rising edge.
   always @(negedge clk) begin
      if (frame_done) done_cnt++;
      if (pixel_valid && pixel_ready) begin
         sb.push_back({exp_base + 16'(exp_idx * 4), pixel_data});
         exp_idx++;
         acc_cnt++;
      end
      if (wr_valid && wr_ready) begin
         checks++;
         assert (sb.size() > 0) else begin
            failures++;
            $error("FAIL sb_underflow observed=write addr %0h expected=no write", wr_addr);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("wr_addr", 48'(wr_addr), 48'(e[47:32]));
            chk("wr_data", 48'(wr_data), 48'(e[31:0]));
         end
         nwr++;
         last_pop_cyc = cyc;
         last_addr = wr_addr;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic [15:0] b);
      base_addr = b;
      start = 1;
      exp_base = b;
      exp_idx = 0;
      tick();
      start = 0;
   endtask

   task automatic send(input logic [31:0] d);
      int n;
      pixel_valid = 1;
      pixel_data = d;
      for (n = 0; n < 50; n++) begin
         @(negedge clk);
         if (pixel_ready) break;
      end
      chk("accept_in_time", 48'(n < 50), 48'h1);
      tick();
      pixel_valid = 0;
   endtask

   task automatic wait_done();
      int n;
      for (n = 0; n < 100; n++) begin
         @(negedge clk);
         if (frame_done) break;
      end
      chk("done_seen", 48'(frame_done), 48'h1);
      chk("done_after_last_pop", 48'(cyc), 48'(last_pop_cyc + 1));
      @(negedge clk);
      chk("done_one_cycle", 48'(frame_done), 48'h0);
      chk("busy_after_done", 48'(busy), 48'h0);
      chk("sb_drained", 48'(sb.size()), 48'h0);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tick();
      tick();
      chk("rst_pixel_ready", 48'(pixel_ready), 48'h0);
      chk("rst_wr_valid", 48'(wr_valid), 48'h0);
      chk("rst_wr_addr", 48'(wr_addr), 48'h0);
      chk("rst_wr_data", 48'(wr_data), 48'h0);
      chk("rst_busy", 48'(busy), 48'h0);
      chk("rst_frame_done", 48'(frame_done), 48'h0);
      rst_n = 1;
      pixel_valid = 1;
      repeat (4) begin
         tick();
         chk("idle_pixel_ready", 48'(pixel_ready), 48'h0);
         chk("idle_wr_valid", 48'(wr_valid), 48'h0);
         chk("idle_busy", 48'(busy), 48'h0);
         chk("idle_frame_done", 48'(frame_done), 48'h0);
      end
      pixel_valid = 0;

      wr_ready = 1;
      w0 = nwr;
      start_frame(16'h1000);
      chk("run_busy", 48'(busy), 48'h1);
      for (int k = 1; k <= 8; k++) send(32'(k));
      wait_done();
      chk("frame1_writes", 48'(nwr - w0), 48'h8);
      chk("frame1_last_addr", 48'(last_addr), 48'h101C);

      wr_ready = 0;
      w0 = nwr;
      a0 = acc_cnt;
      start_frame(16'h1000);
      for (int k = 1; k <= 4; k++) send(32'h10 + 32'(k));
      pixel_valid = 1;
      pixel_data = 32'h15;
      repeat (5) begin
         @(negedge clk);
         chk("bp_ready_low", 48'(pixel_ready), 48'h0);
         chk("bp_wr_valid", 48'(wr_valid), 48'h1);
         chk("bp_addr_hold", 48'(wr_addr), 48'h1000);
         chk("bp_data_hold", 48'(wr_data), 48'h11);
      end
      chk("bp_accepts", 48'(acc_cnt - a0), 48'h4);
      tick();
      wr_ready = 1;
      for (int k = 5; k <= 8; k++) send(32'h10 + 32'(k));
      wait_done();
      chk("bp_writes", 48'(nwr - w0), 48'h8);

      w0 = nwr;
      start_frame(16'h1000);
      send(32'h21);
      send(32'h22);
      base_addr = 16'h2000;
      start = 1;
      tick();
      start = 0;
      chk("start_ignored_busy", 48'(busy), 48'h1);
      for (int k = 3; k <= 8; k++) send(32'h20 + 32'(k));
      wait_done();
      chk("start_ignored_writes", 48'(nwr - w0), 48'h8);
      chk("start_ignored_last", 48'(last_addr), 48'h101C);

      start_frame(16'hFFF8);
      for (int k = 1; k <= 8; k++) send(32'h30 + 32'(k));
      wait_done();
      chk("wrap_last_addr", 48'(last_addr), 48'h0014);

      wr_ready = 0;
      start_frame(16'h3000);
      for (int k = 1; k <= 3; k++) send(32'h40 + 32'(k));
      rst_n = 0;
      sb.delete();
      tick();
      rst_n = 1;
      chk("midrst_wr_valid", 48'(wr_valid), 48'h0);
      chk("midrst_busy", 48'(busy), 48'h0);
      chk("midrst_pixel_ready", 48'(pixel_ready), 48'h0);
      chk("midrst_wr_addr", 48'(wr_addr), 48'h0);
      wr_ready = 1;
      w0 = nwr;
      repeat (3) tick();
      chk("midrst_no_writes", 48'(nwr - w0), 48'h0);
      start_frame(16'h4000);
      for (int k = 1; k <= 8; k++) send(32'h50 + 32'(k));
      wait_done();
      chk("postrst_writes", 48'(nwr - w0), 48'h8);
      chk("postrst_last_addr", 48'(last_addr), 48'h401C);
      chk("frame_done_count", 48'(done_cnt), 48'h5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
